// File: rtl/a_io_l3_in_serialize_a_m_axi_pkg.sv
// Shared types and default geometry for the A_IO_L3_in_serialize_A m_axi adapter.
// Blocks take their own overridable parameters, which default to the values held here.
package a_io_l3_in_serialize_a_m_axi_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 64;
   localparam int DEF_LEN_WIDTH  = 32;
   localparam int DEF_MAX_BURST  = 16;
   localparam int DEF_BOUNDARY   = 4096;

   localparam int BYTES      = DEF_DATA_WIDTH / 8;
   localparam int ADDR_LSB   = $clog2(BYTES);
   localparam int PAGE_BITS  = $clog2(DEF_BOUNDARY);
   localparam int BURST_BITS = $clog2(DEF_MAX_BURST) + 1;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

endpackage

// File: rtl/a_io_l3_in_serialize_a_m_axi_burst_len_calc.sv
// Beats in the next burst: the smallest of the remaining length, MAX_BURST
// and the number of beats left before the next page boundary.
module a_io_l3_in_serialize_a_m_axi_burst_len_calc
   import a_io_l3_in_serialize_a_m_axi_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
   parameter int MAX_BURST  = DEF_MAX_BURST,
   parameter int BOUNDARY   = DEF_BOUNDARY,
   localparam int BEAT_LSB  = $clog2(DATA_WIDTH / 8),
   localparam int PG_BITS   = $clog2(BOUNDARY),
   localparam int IDX_BITS  = PG_BITS - BEAT_LSB,
   localparam int BB        = $clog2(MAX_BURST) + 1
)(
   input  logic [IDX_BITS-1:0]  i_beat_idx,
   input  logic [LEN_WIDTH-1:0] i_rem,
   output logic [BB-1:0]        o_n
);

   localparam int CW0 = (LEN_WIDTH > IDX_BITS + 1) ? LEN_WIDTH : IDX_BITS + 1;
   localparam int CW  = (CW0 > BB) ? CW0 : BB;

   logic [CW-1:0] w_page_room;
   logic [CW-1:0] w_n;

   always_comb begin
      // Beats per page minus the beat index inside the page; never zero.
      w_page_room = CW'(BOUNDARY / (DATA_WIDTH / 8)) - CW'(i_beat_idx);
      w_n         = CW'(i_rem);
      if (CW'(MAX_BURST) < w_n) w_n = CW'(MAX_BURST);
      if (w_page_room < w_n)    w_n = w_page_room;
   end

   assign o_n = BB'(w_n);

endmodule

// File: rtl/a_io_l3_in_serialize_a_m_axi_burst_split.sv
// Read-request burst splitter: one kernel request in, a stream of AXI-legal
// bursts (<= MAX_BURST beats, no page crossing) out to the request FIFO.
module a_io_l3_in_serialize_a_m_axi_burst_split
   import a_io_l3_in_serialize_a_m_axi_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
   parameter int MAX_BURST  = DEF_MAX_BURST,
   parameter int BOUNDARY   = DEF_BOUNDARY
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_clk_en,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic [ADDR_WIDTH-1:0] i_in_addr,
   input  logic [LEN_WIDTH-1:0]  i_in_len,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [ADDR_WIDTH-1:0] o_out_addr,
   output logic [7:0]            o_out_len,
   output logic                  o_out_last
);

   localparam int BEAT_LSB = $clog2(DATA_WIDTH / 8);
   localparam int PG_BITS  = $clog2(BOUNDARY);
   localparam int BB       = $clog2(MAX_BURST) + 1;

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cur_addr, r_out_addr;
   logic [LEN_WIDTH-1:0]  r_rem;
   logic [7:0]            r_out_len;
   logic                  r_out_last;

   logic                  w_accept, w_fire, w_load;
   logic [ADDR_WIDTH-1:0] w_src_addr, w_next_addr;
   logic [LEN_WIDTH-1:0]  w_src_rem, w_next_rem;
   logic [BB-1:0]         w_n;

   assign w_accept = i_clk_en & i_in_valid & (r_state == IDLE);
   assign w_fire   = i_clk_en & (r_state == EMIT) & i_out_ready;

   // NOTE: in IDLE the first burst is sized straight from the request inputs so it
   // is registered on the accepting edge; r_cur_addr/r_rem then hold the residue.
   assign w_src_addr  = (r_state == IDLE) ? ((i_in_addr >> BEAT_LSB) << BEAT_LSB) : r_cur_addr;
   assign w_src_rem   = (r_state == IDLE) ? i_in_len : r_rem;
   assign w_next_addr = w_src_addr + (ADDR_WIDTH'(w_n) << BEAT_LSB);
   assign w_next_rem  = w_src_rem - LEN_WIDTH'(w_n);
   assign w_load      = (r_state == IDLE) ? (w_accept && (i_in_len != '0))
                                          : (w_fire && !r_out_last);

   a_io_l3_in_serialize_a_m_axi_burst_len_calc #(
      .DATA_WIDTH (DATA_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH),
      .MAX_BURST  (MAX_BURST),
      .BOUNDARY   (BOUNDARY)
   ) u_len_calc (
      .i_beat_idx (w_src_addr[PG_BITS-1:BEAT_LSB]),
      .i_rem      (w_src_rem),
      .o_n        (w_n)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept && (i_in_len != '0)) w_state_nxt = EMIT;
         EMIT:    if (w_fire && r_out_last)         w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Reset takes precedence over clk_en so a frozen pipeline can still be cleared.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cur_addr <= '0;
         r_rem      <= '0;
         r_out_addr <= '0;
         r_out_len  <= '0;
         r_out_last <= 1'b0;
      end else if (w_load) begin
         r_out_addr <= w_src_addr;
         r_out_len  <= 8'(w_n - BB'(1));
         r_out_last <= (w_next_rem == '0);
         r_cur_addr <= w_next_addr;
         r_rem      <= w_next_rem;
      end
   end

   assign o_in_ready  = (r_state == IDLE);
   assign o_out_valid = (r_state == EMIT);
   assign o_out_addr  = r_out_addr;
   assign o_out_len   = r_out_len;
   assign o_out_last  = r_out_last;

endmodule

// File: tb/tb_a_io_l3_in_serialize_a_m_axi_burst_split.sv
// Self-checking bench for the burst splitter: directed cases plus randomized
// requests scored against an arithmetic reference model of the burst sequence.
module tb_a_io_l3_in_serialize_a_m_axi_burst_split;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_addr;
   logic [31:0] in_len;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_addr;
   logic [7:0]  out_len;
   logic        out_last;

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  len;
      logic        last;
   } burst_t;

   burst_t exp_q[$];
   int     n_checks = 0;
   int     n_fails  = 0;

   always #5 clk = ~clk;

   a_io_l3_in_serialize_a_m_axi_burst_split dut (
      .clk         (clk),
      .reset       (reset),
      .i_clk_en    (clk_en),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_addr   (in_addr),
      .i_in_len    (in_len),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_addr  (out_addr),
      .o_out_len   (out_len),
      .o_out_last  (out_last)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: split [addr, addr+len beats) into <=16-beat bursts that stay within 4 KiB pages.
   function automatic void model(input logic [63:0] addr, input logic [31:0] len);
      logic [63:0]     a;
      longint unsigned rem, room, n;
      burst_t          b;
      a   = addr & ~64'h3;
      rem = len;
      while (rem != 0) begin
         room = (4096 - (a % 4096)) / 4;
         n    = rem;
         if (n > 16)   n = 16;
         if (n > room) n = room;
         b.addr = a;
         b.len  = 8'(n - 1);
         b.last = (rem == n);
         exp_q.push_back(b);
         a   = a + 64'(n * 4);
         rem = rem - n;
      end
   endfunction

   // One request; rnd randomizes out_ready/clk_en, stall_idx holds out_ready low for
   // 5 cycles on that burst, freeze_idx drops clk_en for 3 cycles on that burst.
   task automatic do_req(input logic [63:0] addr, input logic [31:0] len,
                         input bit rnd, input int stall_idx, input int freeze_idx);
      burst_t e;
      int     bidx = 0, stall_left = 5, freeze_left = 3;
      bit     done = 0;
      model(addr, len);
      @(negedge clk);
      check("in_ready_idle", in_ready, 1);
      in_valid  = 1;
      in_addr   = addr;
      in_len    = len;
      clk_en    = 1;
      out_ready = 0;
      @(negedge clk);
      in_valid = 0;
      in_addr  = {$urandom, $urandom};
      in_len   = $urandom;
      if (len == 0) begin
         check("null_no_valid", out_valid, 0);
         check("null_in_ready", in_ready, 1);
         return;
      end
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         check("valid_in_flight", out_valid, 1);
         check("in_ready_busy", in_ready, 0);
         out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         clk_en    = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
         if (bidx == stall_idx && stall_left > 0) begin
            out_ready = 0;
            stall_left--;
         end
         if (bidx == freeze_idx && freeze_left > 0) begin
            clk_en    = 0;
            out_ready = 1;
            freeze_left--;
         end
         check("burst_expected", exp_q.size() != 0, 1);
         if (exp_q.size() == 0) begin
            done = 1;
         end else begin
            e = exp_q[0];
            check("out_addr", out_addr, e.addr);
            check("out_len", out_len, e.len);
            check("out_last", out_last, e.last);
            if (out_ready && clk_en) begin
               void'(exp_q.pop_front());
               bidx++;
               if (e.last) done = 1;
            end
         end
         @(negedge clk);
      end
      check("req_done", done, 1);
      check("after_valid", out_valid, 0);
      check("after_in_ready", in_ready, 1);
      check("all_bursts_seen", exp_q.size(), 0);
      exp_q.delete();
      clk_en    = 1;
      out_ready = 0;
   endtask

   initial begin
      reset     = 1;
      clk_en    = 1;
      in_valid  = 0;
      out_ready = 0;
      in_addr   = '0;
      in_len    = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_addr", out_addr, 0);
      check("rst_out_len", out_len, 0);
      check("rst_out_last", out_last, 0);
      reset = 0;

      do_req(64'h0, 40, 0, -1, -1);             // 16+16+8 beats back to back
      do_req(64'hFF0, 8, 0, -1, -1);            // split at the 0x1000 page
      do_req(64'h3, 1, 0, -1, -1);              // low address bits dropped
      do_req(64'h0, 40, 0, 1, -1);              // 5-cycle backpressure on burst 2
      do_req(64'h0, 0, 0, -1, -1);              // null request
      do_req(64'h100, 2, 0, -1, -1);
      do_req(64'h0, 40, 0, -1, 1);              // clk_en low mid-split
      do_req(64'hFFFF_FFFF_FFFF_FFF0, 8, 0, -1, -1); // address wrap

      // Reset after the first burst of a 40-beat request drops the remainder.
      @(negedge clk);
      in_valid  = 1;
      in_addr   = 64'h0;
      in_len    = 40;
      out_ready = 1;
      @(negedge clk);
      in_valid = 0;
      check("rstmid_first_valid", out_valid, 1);
      check("rstmid_first_len", out_len, 15);
      @(negedge clk);
      check("rstmid_second_addr", out_addr, 64'h40);
      reset = 1;
      @(negedge clk);
      reset = 0;
      check("rstmid_valid", out_valid, 0);
      check("rstmid_in_ready", in_ready, 1);
      check("rstmid_out_addr", out_addr, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rstmid_no_burst", out_valid, 0);
      end
      out_ready = 0;

      for (int i = 0; i < 14; i++) begin
         logic [63:0] a;
         a = {$urandom, $urandom};
         if (i % 2 == 0) a = 64'(12'hF00 + $urandom_range(0, 255));
         do_req(a, 32'($urandom_range(0, 80)), 1,
                $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
